// File: rtl/atpg_path_pattern_applier_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | atpg_path_pattern_applier_if : table load, run control, CUT I/O    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface atpg_path_pattern_applier_if #(
  parameter int PI_W  = 1,
  parameter int PO_W  = 1,
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [PI_W-1:0] wr_stim;
  logic [PO_W-1:0] wr_exp;
  logic [PO_W-1:0] wr_mask;
  logic [AW:0]     num_pat;
  logic            start;
  logic [PI_W-1:0] cut_pi;
  logic [PO_W-1:0] cut_po;
  logic            busy;
  logic            done;
  logic            pass;
  logic [AW:0]     fail_count;
  logic [AW-1:0]   first_fail;
  logic            fail_valid;

  modport master (
    output wr_en, wr_addr, wr_stim, wr_exp, wr_mask, num_pat, start, cut_po,
    input  cut_pi, busy, done, pass, fail_count, first_fail, fail_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_stim, wr_exp, wr_mask, num_pat, start, cut_po,
    output cut_pi, busy, done, pass, fail_count, first_fail, fail_valid
  );
endinterface
`default_nettype wire

// File: rtl/atpg_path_pattern_applier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | atpg_path_pattern_applier : applies a stimulus/expected/mask table |
// | to a path under test and summarises mismatches.  rev 1.0           |
// +--------------------------------------------------------------------+
module atpg_path_pattern_applier #(
  parameter int PI_W   = 1,
  parameter int PO_W   = 1,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  atpg_path_pattern_applier_if.slave   bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(SETTLE + 1);
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] SETTLE_N = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PI_W-1:0] r_stim_mem [DEPTH];
  logic [PO_W-1:0] r_exp_mem  [DEPTH];
  logic [PO_W-1:0] r_mask_mem [DEPTH];

  logic [AW-1:0]   r_idx;
  logic [AW:0]     r_n;
  logic [CW-1:0]   r_cnt;
  logic [PI_W-1:0] r_cut_pi;
  logic            r_pass;
  logic [AW:0]     r_fail_count;
  logic [AW-1:0]   r_first_fail;
  logic            r_fail_valid;

  logic            w_busy;
  logic            w_done;
  logic [AW:0]     w_n_clamp;
  logic            w_capture;
  logic            w_mismatch;
  logic            w_last_pat;
  logic [AW:0]     w_fail_count_nxt;
  logic            w_wr_accept;

  assign w_n_clamp  = (bus.num_pat > DEPTH_N) ? DEPTH_N : bus.num_pat;
  assign w_capture  = (r_state == S_WAIT) && (r_cnt == CNT_ONE);
  assign w_mismatch = |((bus.cut_po ^ r_exp_mem[r_idx]) & r_mask_mem[r_idx]);
  assign w_last_pat = (({1'b0, r_idx} + 1'b1) == r_n);

  // Saturate instead of wrapping so a full-table failure never reads as a pass.
  assign w_fail_count_nxt = (w_mismatch && !(&r_fail_count)) ?
                            (r_fail_count + 1'b1) : r_fail_count;

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_APPLY;
        end
      end
      S_APPLY: begin
        w_busy      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (w_capture) begin
          w_state_nxt = w_last_pat ? S_DONE : S_APPLY;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Table loads are locked out for the whole run and its done cycle.
  assign w_wr_accept = bus.wr_en && !w_busy && !w_done;

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_stim_mem[bus.wr_addr] <= bus.wr_stim;
      r_exp_mem[bus.wr_addr]  <= bus.wr_exp;
      r_mask_mem[bus.wr_addr] <= bus.wr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_n          <= '0;
      r_cnt        <= '0;
      r_cut_pi     <= '0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_n          <= w_n_clamp;
            r_idx        <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= (w_n_clamp == '0);
          end
        end
        S_APPLY: begin
          r_cut_pi <= r_stim_mem[r_idx];
          r_cnt    <= SETTLE_N;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_capture) begin
            r_fail_count <= w_fail_count_nxt;
            if (w_mismatch && !r_fail_valid) begin
              r_first_fail <= r_idx;
              r_fail_valid <= 1'b1;
            end
            if (w_last_pat) begin
              r_pass <= (w_fail_count_nxt == '0);
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cut_pi     = r_cut_pi;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.pass       = r_pass;
  assign bus.fail_count = r_fail_count;
  assign bus.first_fail = r_first_fail;
  assign bus.fail_valid = r_fail_valid;
endmodule
`default_nettype wire

// File: tb/tb_atpg_path_pattern_applier.sv
`default_nettype none
// Bench for atpg_path_pattern_applier: table-level reference model, XOR-keyed loopback path.
module tb_atpg_path_pattern_applier;
  localparam int W      = 4;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 2;
  localparam int AW     = $clog2(DEPTH);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] po_key = '0;
  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] stim_m [DEPTH];
  logic [W-1:0] exp_m  [DEPTH];
  logic [W-1:0] mask_m [DEPTH];
  logic [W-1:0] last_pi = '0;

  atpg_path_pattern_applier_if #(.PI_W(W), .PO_W(W), .DEPTH(DEPTH)) bus ();

  atpg_path_pattern_applier #(
    .PI_W(W), .PO_W(W), .DEPTH(DEPTH), .SETTLE(SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The path under test: identity or inversion of selected bits.
  assign bus.cut_po = bus.cut_pi ^ po_key;

  task automatic write_entry(input int a, input logic [W-1:0] s, input logic [W-1:0] e,
                             input logic [W-1:0] m);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[AW-1:0];
    bus.wr_stim = s;
    bus.wr_exp  = e;
    bus.wr_mask = m;
    @(negedge clk);
    bus.wr_en = 1'b0;
    stim_m[a] = s;
    exp_m[a]  = e;
    mask_m[a] = m;
  endtask

  task automatic run_check(input string tag, input int req, input logic [W-1:0] key,
                           input bit disturb);
    int n, exp_fails, exp_first, done_cyc, pat;
    bit exp_fv;
    logic [W-1:0] exp_pi;
    n = (req > DEPTH) ? DEPTH : req;
    exp_fails = 0;
    exp_first = 0;
    exp_fv    = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (|(((stim_m[j] ^ key) ^ exp_m[j]) & mask_m[j])) begin
        if (!exp_fv) begin
          exp_first = j;
          exp_fv    = 1'b1;
        end
        exp_fails++;
      end
    end
    po_key = key;
    done_cyc = (n == 0) ? 1 : 1 + n * (1 + SETTLE);

    @(negedge clk);
    bus.num_pat = req[AW:0];
    bus.start   = 1'b1;
    for (int k = 1; k <= done_cyc; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      checks++;
      if (bus.busy !== (k < done_cyc)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", tag, k, bus.busy, (k < done_cyc));
      end
      checks++;
      if (bus.done !== (k == done_cyc)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b expected %b", tag, k, bus.done, (k == done_cyc));
      end
      if (k >= 2 && n > 0) begin
        pat = (k - 2) / (SETTLE + 1);
        if (pat > n - 1) pat = n - 1;
        exp_pi = stim_m[pat];
      end else begin
        exp_pi = last_pi;
      end
      checks++;
      if (bus.cut_pi !== exp_pi) begin
        errors++;
        $display("FAIL %s cut_pi cycle %0d: got %h expected %h", tag, k, bus.cut_pi, exp_pi);
      end
      if (disturb && k == 3) begin
        bus.start   = 1'b1;
        bus.num_pat = 1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_stim = ~stim_m[0];
        bus.wr_exp  = ~exp_m[0];
        bus.wr_mask = ~mask_m[0];
      end
    end
    if (n > 0) last_pi = stim_m[n-1];

    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after done: got busy=%b done=%b expected 0 0", tag, bus.busy, bus.done);
    end
    checks++;
    if (bus.pass !== (exp_fails == 0)) begin
      errors++;
      $display("FAIL %s pass: got %b expected %b", tag, bus.pass, (exp_fails == 0));
    end
    checks++;
    if (bus.fail_count !== exp_fails[AW:0]) begin
      errors++;
      $display("FAIL %s fail_count: got %0d expected %0d", tag, bus.fail_count, exp_fails);
    end
    if (n > 0) begin
      checks++;
      if (bus.fail_valid !== exp_fv) begin
        errors++;
        $display("FAIL %s fail_valid: got %b expected %b", tag, bus.fail_valid, exp_fv);
      end
    end
    if (exp_fv) begin
      checks++;
      if (bus.first_fail !== exp_first[AW-1:0]) begin
        errors++;
        $display("FAIL %s first_fail: got %0d expected %0d", tag, bus.first_fail, exp_first);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.fail_valid} !== 4'b0000 ||
        bus.cut_pi !== '0 || bus.fail_count !== '0 || bus.first_fail !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b pass=%b fv=%b pi=%h fc=%0d ff=%0d expected all 0",
               bus.busy, bus.done, bus.pass, bus.fail_valid, bus.cut_pi, bus.fail_count,
               bus.first_fail);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    write_entry(0, 4'h0, 4'h0, 4'h1);
    write_entry(1, 4'h1, 4'h1, 4'h1);
    run_check("loopback", 2, '0, 1'b0);
  endtask

  task automatic test_inverted();
    run_check("inverted", 2, '1, 1'b0);
  endtask

  task automatic test_masked();
    write_entry(0, 4'h0, 4'h1, 4'h1);
    write_entry(1, 4'h1, 4'h1, 4'h0);
    run_check("masked", 2, '1, 1'b0);
  endtask

  task automatic test_zero_and_clamp();
    logic [W-1:0] s;
    run_check("zero_pat", 0, '0, 1'b0);
    for (int j = 0; j < DEPTH; j++) begin
      s = W'($urandom);
      write_entry(j, s, s, W'($urandom_range(1, (1 << W) - 1)));
    end
    run_check("clamp", 20, '1, 1'b0);
    checks++;
    if (bus.fail_count !== 5'd16) begin
      errors++;
      $display("FAIL clamp_count: got %0d expected 16", bus.fail_count);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] key;
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 3; w++) begin
        write_entry($urandom_range(0, DEPTH - 1), W'($urandom), W'($urandom), W'($urandom));
      end
      case ($urandom_range(0, 2))
        0:       key = '0;
        1:       key = '1;
        default: key = W'($urandom);
      endcase
      run_check("random", $urandom_range(0, 20), key, 1'b0);
    end
  endtask

  task automatic test_back_to_back_disturb();
    write_entry(0, 4'h5, 4'h5, 4'hF);
    write_entry(1, 4'hA, 4'hA, 4'hF);
    run_check("disturb", 2, '0, 1'b1);
    run_check("after_disturb", 2, '0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.num_pat = 2;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.fail_valid} !== 4'b0000 ||
        bus.cut_pi !== '0 || bus.fail_count !== '0 || bus.first_fail !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b pass=%b fv=%b pi=%h fc=%0d expected all 0",
               bus.busy, bus.done, bus.pass, bus.fail_valid, bus.cut_pi, bus.fail_count);
    end
    rst_n = 1'b1;
    last_pi = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
    end
    run_check("after_reset", 2, '0, 1'b0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_stim = '0;
    bus.wr_exp  = '0;
    bus.wr_mask = '0;
    bus.num_pat = '0;
    bus.start   = 1'b0;
    test_reset();
    test_loopback();
    test_inverted();
    test_masked();
    test_zero_and_clamp();
    test_random();
    test_back_to_back_disturb();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
